// File: rtl/seg_scan_driver_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
// Segment patterns are active-high {g,f,e,d,c,b,a}; the bus itself is active-low.
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Prefixed so the names do not clash with the GUARD timing parameter.
    typedef enum logic {
        S_DISPLAY = 1'b0,
        S_GUARD   = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_scan_driver_hex_decode.sv
// Hex nibble to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver: dwell/guard scan FSM, frame-boundary
// update handshake, leading-zero suppression and registered active-low outputs.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 50000,
    parameter int GUARD      = 500,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    upd_req,
    input  logic                    lz_en,
    output logic                    upd_pending,
    output logic                    upd_done,
    output logic                    frame_start,
    output logic [IDX_W-1:0]        digit_idx,
    output logic [7:0]              Seven_Seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] digits_act_q, digits_act_d;
    logic [NUM_DIGITS-1:0]   dp_act_q, dp_act_d;
    logic [NUM_DIGITS-1:0]   blank_act_q, blank_act_d;
    logic [4*NUM_DIGITS-1:0] digits_pend_q, digits_pend_d;
    logic [NUM_DIGITS-1:0]   dp_pend_q, dp_pend_d;
    logic [NUM_DIGITS-1:0]   blank_pend_q, blank_pend_d;
    logic                    pending_q, pending_d;
    logic                    upd_done_q, upd_done_d;
    logic                    frame_start_q, frame_start_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    boundary;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_run;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [6:0]              cur_seg;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CNT_W'(1);
        idx_d         = idx_q;
        boundary      = 1'b0;
        frame_start_d = 1'b0;
        case (state_q)
            S_DISPLAY: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = S_GUARD;
                    cnt_d   = '0;
                end
            end
            S_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = S_DISPLAY;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d         = '0;
                        boundary      = 1'b1;
                        frame_start_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_DISPLAY;
                cnt_d   = '0;
            end
        endcase
    end

    // A request on the boundary cycle bypasses pending so it is never a frame late.
    always_comb begin
        digits_act_d  = digits_act_q;
        dp_act_d      = dp_act_q;
        blank_act_d   = blank_act_q;
        digits_pend_d = digits_pend_q;
        dp_pend_d     = dp_pend_q;
        blank_pend_d  = blank_pend_q;
        pending_d     = pending_q;
        upd_done_d    = 1'b0;
        if (boundary) begin
            if (upd_req) begin
                digits_act_d = digits_in;
                dp_act_d     = dp_in;
                blank_act_d  = blank_in;
                pending_d    = 1'b0;
                upd_done_d   = 1'b1;
            end else if (pending_q) begin
                digits_act_d = digits_pend_q;
                dp_act_d     = dp_pend_q;
                blank_act_d  = blank_pend_q;
                pending_d    = 1'b0;
                upd_done_d   = 1'b1;
            end
        end else if (upd_req) begin
            digits_pend_d = digits_in;
            dp_pend_d     = dp_in;
            blank_pend_d  = blank_in;
            pending_d     = 1'b1;
        end
    end

    // Suppression walks down from the top digit; digit 0 is never included.
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run    = zero_run & (digits_act_q[4*i +: 4] == 4'h0);
            lz_blank[i] = lz_en & zero_run;
        end
    end

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nibble = digits_act_q[4*i +: 4];
                cur_dp     = dp_act_q[i];
                cur_blank  = blank_act_q[i] | lz_blank[i];
            end
        end
    end

    seg_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '1;
        if (state_q == S_DISPLAY && !cur_blank) begin
            seg_d = ~{cur_dp, cur_seg};
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_DISPLAY;
            cnt_q         <= '0;
            idx_q         <= '0;
            digits_act_q  <= '0;
            dp_act_q      <= '0;
            blank_act_q   <= '1;
            digits_pend_q <= '0;
            dp_pend_q     <= '0;
            blank_pend_q  <= '0;
            pending_q     <= 1'b0;
            upd_done_q    <= 1'b0;
            frame_start_q <= 1'b0;
            seg_q         <= SEG_OFF;
            an_q          <= '1;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            digits_act_q  <= digits_act_d;
            dp_act_q      <= dp_act_d;
            blank_act_q   <= blank_act_d;
            digits_pend_q <= digits_pend_d;
            dp_pend_q     <= dp_pend_d;
            blank_pend_q  <= blank_pend_d;
            pending_q     <= pending_d;
            upd_done_q    <= upd_done_d;
            frame_start_q <= frame_start_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign upd_pending = pending_q;
    assign upd_done    = upd_done_q;
    assign frame_start = frame_start_q;
    assign digit_idx   = idx_q;
    assign Seven_Seg   = seg_q;
    assign an          = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=4, DWELL=4, GUARD=1 (20-cycle frames).
// Cycle f of a frame is sampled on the falling edge; outputs there show the scan state of f-1.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        upd_req;
    logic        lz_en;
    logic        upd_pending;
    logic        upd_done;
    logic        frame_start;
    logic [1:0]  digit_idx;
    logic [7:0]  Seven_Seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit pend_m = 1'b0;

    logic [7:0] exp_seg [4];
    logic [3:0] exp_lit;
    logic [3:0] req_dp;
    logic [3:0] req_blank;

    // Active-low bus value ~{0, pattern} for each nibble, worked out by hand.
    logic [7:0] sweep_tab [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg_scan_driver #(
        .NUM_DIGITS (4),
        .DWELL      (4),
        .GUARD      (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .upd_req     (upd_req),
        .lz_en       (lz_en),
        .upd_pending (upd_pending),
        .upd_done    (upd_done),
        .frame_start (frame_start),
        .digit_idx   (digit_idx),
        .Seven_Seg   (Seven_Seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [15:0] dig);
        upd_req = req;
        if (req) begin
            digits_in = dig;
            dp_in     = req_dp;
            blank_in  = req_blank;
        end
    endtask

    task automatic setExpect(input logic [3:0] lit, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
        exp_lit    = lit;
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
    endtask

    // Walks ncyc cycles of one frame, checking every output and issuing up to two requests.
    task automatic runFrame(input logic exp_fs, input logic exp_done,
                            input int req_a, input logic [15:0] dig_a,
                            input int req_b, input logic [15:0] dig_b, input int ncyc);
        int d;
        int pos;
        logic r;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        for (int f = 0; f < ncyc; f++) begin
            d   = f / 5;
            pos = f % 5;
            if (pos != 0 && exp_lit[d]) begin
                e_an  = ~(4'b0001 << d);
                e_seg = exp_seg[d];
            end else begin
                e_an  = 4'hF;
                e_seg = 8'hFF;
            end
            checkOutput("an", 32'(an), 32'(e_an));
            checkOutput("Seven_Seg", 32'(Seven_Seg), 32'(e_seg));
            checkOutput("digit_idx", 32'(digit_idx), 32'(d));
            checkOutput("frame_start", 32'(frame_start), (f == 0) ? 32'(exp_fs) : 32'd0);
            checkOutput("upd_done", 32'(upd_done), (f == 0) ? 32'(exp_done) : 32'd0);
            checkOutput("upd_pending", 32'(upd_pending), 32'(pend_m));
            checkOutput("an_onecold", 32'($countones(~an) <= 1), 32'd1);
            r = (f == req_a) || (f == req_b);
            applyStimulus(r, (f == req_b) ? dig_b : dig_a);
            if (r && f != 19) pend_m = 1'b1;
            else if (f == 19) pend_m = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        blank_in  = '0;
        upd_req   = 1'b0;
        lz_en     = 1'b0;
        req_dp    = 4'b0010;
        req_blank = 4'b0000;
        repeat (3) @(negedge clk);
        checkOutput("rst_an", 32'(an), 32'hF);
        checkOutput("rst_seg", 32'(Seven_Seg), 32'hFF);
        checkOutput("rst_pending", 32'(upd_pending), 32'd0);
        checkOutput("rst_done", 32'(upd_done), 32'd0);
        checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
        checkOutput("rst_idx", 32'(digit_idx), 32'd0);
        rst_n = 1'b1;
        cyc   = 0;

        $display("[TB] dark first frame, request 12AF");
        setExpect(4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        runFrame(1'b0, 1'b0, 2, 16'h12AF, -1, 16'h0, 20);

        $display("[TB] 12AF frame, request 0005");
        req_dp = 4'b0000;
        setExpect(4'b1111, 8'h8E, 8'h08, 8'hA4, 8'hF9);
        runFrame(1'b1, 1'b1, 3, 16'h0005, -1, 16'h0, 20);

        $display("[TB] leading-zero suppression on 0005, request 0000");
        lz_en = 1'b1;
        setExpect(4'b0001, 8'h92, 8'hFF, 8'hFF, 8'hFF);
        runFrame(1'b1, 1'b1, 4, 16'h0000, -1, 16'h0, 20);

        $display("[TB] all-zero frame, two requests 1111 then 2222");
        setExpect(4'b0001, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
        runFrame(1'b1, 1'b1, 2, 16'h1111, 7, 16'h2222, 20);

        $display("[TB] 2222 frame, request 3333 on the boundary cycle");
        setExpect(4'b1111, 8'hA4, 8'hA4, 8'hA4, 8'hA4);
        runFrame(1'b1, 1'b1, 19, 16'h3333, -1, 16'h0, 20);

        $display("[TB] 3333 frame via bypass");
        setExpect(4'b1111, 8'hB0, 8'hB0, 8'hB0, 8'hB0);
        runFrame(1'b1, 1'b1, -1, 16'h0, -1, 16'h0, 20);

        $display("[TB] pending 4444 then reset during digit 2");
        runFrame(1'b1, 1'b0, 3, 16'h4444, -1, 16'h0, 12);
        rst_n  = 1'b0;
        pend_m = 1'b0;
        #1;
        checkOutput("async_an", 32'(an), 32'hF);
        checkOutput("async_seg", 32'(Seven_Seg), 32'hFF);
        checkOutput("async_pending", 32'(upd_pending), 32'd0);
        checkOutput("async_idx", 32'(digit_idx), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        lz_en = 1'b0;

        $display("[TB] dark frames after reset, then nibble sweep on digit 0");
        setExpect(4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        runFrame(1'b0, 1'b0, -1, 16'h0, -1, 16'h0, 20);
        req_blank = 4'b1110;
        runFrame(1'b1, 1'b0, 2, 16'h0000, -1, 16'h0, 20);
        for (int n = 0; n < 16; n++) begin
            setExpect(4'b0001, sweep_tab[n], 8'hFF, 8'hFF, 8'hFF);
            runFrame(1'b1, 1'b1, (n < 15) ? 2 : -1, 16'(n + 1), -1, 16'h0, 20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
